// File: rtl/jtag_master_pkg.sv
`default_nettype none
// ============================================================================
// Module : jtag_master_pkg
// Brief  : Shared opcodes, FSM state encodings and constants for the JTAG master
// Rev    : 1.0
// ============================================================================
package jtag_master_pkg;

  typedef enum logic [1:0] {
    OP_DR      = 2'd0,
    OP_IR      = 2'd1,
    OP_TLR     = 2'd2,
    OP_RUNTEST = 2'd3
  } jtag_op_t;

  // Each scan state names the TAP state the target occupies during that TCK period
  localparam logic [3:0] TLR_SEQ = 4'd0;
  localparam logic [3:0] IDLE    = 4'd1;
  localparam logic [3:0] SEL_DR  = 4'd2;
  localparam logic [3:0] SEL_IR  = 4'd3;
  localparam logic [3:0] CAPTURE = 4'd4;
  localparam logic [3:0] SHIFT   = 4'd5;
  localparam logic [3:0] EXIT1   = 4'd6;
  localparam logic [3:0] UPDATE  = 4'd7;
  localparam logic [3:0] RUN     = 4'd8;
  localparam logic [3:0] RESP    = 4'd9;

  localparam int TLR_TMS_ONES = 5;

endpackage
`default_nettype wire

// File: rtl/jtag_scan_master_if.sv
`default_nettype none
// ============================================================================
// Module : jtag_scan_master_if
// Brief  : Command/response handshake bundle between a host and jtag_scan_master
// Rev    : 1.0
// ============================================================================
interface jtag_scan_master_if
  import jtag_master_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic               cmd_valid;
  logic               cmd_ready;
  jtag_op_t           cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/jtag_tck_gen.sv
`default_nettype none
// ============================================================================
// Module : jtag_tck_gen
// Brief  : TCK generator; strobes mark the clock whose edge raises or drops TCK
// Rev    : 1.0
// ============================================================================
module jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  wire  internal_clk,
  input  wire  reg_trstn,
  input  wire  tck_en,
  output logic jtag_tck,
  output logic tck_rise_stb,
  output logic tck_fall_stb
);
  localparam int CW = $clog2(TCK_DIV + 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(TCK_DIV - 1));

  // Disabling snaps the counter back so the next enable starts a fresh low phase
  always_ff @(posedge internal_clk or negedge reg_trstn) begin
    if (!reg_trstn) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!tck_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign jtag_tck     = r_phase;
  assign tck_rise_stb = tck_en & ~r_phase & w_wrap;
  assign tck_fall_stb = tck_en &  r_phase & w_wrap;
endmodule
`default_nettype wire

// File: rtl/jtag_scan_master.sv
`default_nettype none
// ============================================================================
// Module : jtag_scan_master
// Brief  : Host-side JTAG driver running IR/DR scans, TLR and RUNTEST sequences
// Rev    : 1.0
// ============================================================================
module jtag_scan_master
  import jtag_master_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int TCK_DIV = 2,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  wire                internal_clk,
  input  wire                reg_trstn,
  jtag_scan_master_if.slave  bus,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  input  wire                jtag_tdo
);
  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [3:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LEN_W-1:0]   r_len;
  jtag_op_t           r_op;
  logic [MAX_LEN-1:0] r_data;
  logic [MAX_LEN-1:0] r_cap;
  logic [MAX_LEN-1:0] r_rsp;
  logic               r_en;
  logic               r_auto;

  logic               w_rise;
  logic               w_fall;
  logic               w_adv;
  logic               w_last;
  logic               w_ready;
  logic [LEN_W-1:0]   w_len;
  logic [IDX_W-1:0]   w_idx;

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .internal_clk (internal_clk),
    .reg_trstn    (reg_trstn),
    .tck_en       (r_en),
    .jtag_tck     (jtag_tck),
    .tck_rise_stb (w_rise),
    .tck_fall_stb (w_fall)
  );

  assign w_len   = (bus.cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cmd_len;
  assign w_last  = (r_cnt == (CNT_W'(r_len) - 1'b1));
  assign w_idx   = r_cnt[IDX_W-1:0];
  // With TCK stopped (zero-length command) every state lasts one clock
  assign w_adv   = r_en ? w_fall : 1'b1;
  assign w_ready = (r_state == IDLE) || (r_state == RESP);

  assign bus.cmd_ready = w_ready;
  assign bus.busy      = ~w_ready;
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_data  = r_rsp;

  always_comb begin
    jtag_tms = 1'b0;
    case (r_state)
      TLR_SEQ: jtag_tms = (r_cnt < CNT_W'(TLR_TMS_ONES));
      RUN:     jtag_tms = r_en && ((r_op == OP_DR) || (r_op == OP_IR));
      SEL_DR:  jtag_tms = (r_op == OP_IR);
      SHIFT:   jtag_tms = w_last;
      EXIT1:   jtag_tms = 1'b1;
      default: jtag_tms = 1'b0;
    endcase
  end

  assign jtag_tdi = (r_state == SHIFT) ? r_data[w_idx] : 1'b0;

  always_ff @(posedge internal_clk or negedge reg_trstn) begin
    if (!reg_trstn) begin
      r_state <= TLR_SEQ;
      r_cnt   <= '0;
      r_len   <= '0;
      r_op    <= OP_TLR;
      r_data  <= '0;
      r_cap   <= '0;
      r_rsp   <= '0;
      r_en    <= 1'b1;
      r_auto  <= 1'b1;
    end else begin
      if ((r_state == SHIFT) && w_rise) begin
        r_cap[w_idx] <= jtag_tdo;
      end
      case (r_state)
        IDLE, RESP: begin
          r_state <= IDLE;
          if (bus.cmd_valid) begin
            r_op   <= bus.cmd_op;
            r_len  <= w_len;
            r_data <= bus.cmd_data;
            r_cap  <= '0;
            r_cnt  <= '0;
            if (bus.cmd_op == OP_TLR) begin
              r_state <= TLR_SEQ;
              r_en    <= 1'b1;
            end else begin
              r_state <= RUN;
              r_en    <= (w_len != '0);
            end
          end
        end
        TLR_SEQ: if (w_adv) begin
          if (r_cnt == CNT_W'(TLR_TMS_ONES)) begin
            r_en    <= 1'b0;
            r_auto  <= 1'b0;
            r_cnt   <= '0;
            r_state <= r_auto ? IDLE : RESP;
            if (!r_auto) r_rsp <= r_cap;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // Zero-length commands pass RUN -> UPDATE -> RESP without any TCK
        RUN: if (w_adv) begin
          if (!r_en) begin
            r_state <= UPDATE;
          end else if (r_op != OP_RUNTEST) begin
            r_state <= SEL_DR;
          end else if (w_last) begin
            r_state <= RESP;
            r_en    <= 1'b0;
            r_rsp   <= r_cap;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SEL_DR:  if (w_adv) r_state <= (r_op == OP_IR) ? SEL_IR : CAPTURE;
        SEL_IR:  if (w_adv) r_state <= CAPTURE;
        CAPTURE: if (w_adv) begin
          r_state <= SHIFT;
          r_cnt   <= '0;
        end
        SHIFT: if (w_adv) begin
          if (w_last) r_state <= EXIT1;
          else        r_cnt   <= r_cnt + 1'b1;
        end
        EXIT1:  if (w_adv) r_state <= UPDATE;
        UPDATE: if (w_adv) begin
          r_state <= RESP;
          r_en    <= 1'b0;
          r_rsp   <= r_cap;
        end
        default: begin
          r_state <= IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_jtag_scan_master.sv
`default_nettype none
// ============================================================================
// Module : tb_jtag_scan_master
// Brief  : Scoreboard bench for jtag_scan_master against a behavioural 4-bit-IR TAP
// Rev    : 1.0
// ============================================================================
module tb_jtag_scan_master;
  import jtag_master_pkg::*;

  localparam int          MAX_LEN    = 32;
  localparam int          TCK_DIV    = 2;
  localparam int          LEN_W      = $clog2(MAX_LEN + 1);
  localparam int          PER        = 2 * TCK_DIV;
  localparam logic [3:0]  IR_IDCODE  = 4'h1;
  localparam logic [31:0] IDCODE_VAL = 32'h1BA0_0477;

  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR,
    T_UPDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
  } tap_t;

  logic internal_clk = 1'b0;
  logic reg_trstn    = 1'b0;
  logic jtag_tck, jtag_tms, jtag_tdi;
  logic jtag_tdo     = 1'b0;

  jtag_scan_master_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .TCK_DIV(TCK_DIV), .LEN_W(LEN_W)) dut (
    .internal_clk (internal_clk),
    .reg_trstn    (reg_trstn),
    .bus          (bus),
    .jtag_tck     (jtag_tck),
    .jtag_tms     (jtag_tms),
    .jtag_tdi     (jtag_tdi),
    .jtag_tdo     (jtag_tdo)
  );

  always #5 internal_clk = ~internal_clk;

  int n_tests = 0, n_fail = 0, cyc = 0, t_acc = 0;
  int n_rise = 0, n_shift = 0, n_rsp = 0;
  logic               tms_log[$];
  logic [MAX_LEN-1:0] sb[$];
  logic [MAX_LEN-1:0] sb_exp;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] tms_bits();
    logic [63:0] v = '0;
    foreach (tms_log[i]) v = {v[62:0], tms_log[i]};
    return v;
  endfunction

  function automatic tap_t tap_next(tap_t s, logic t);
    case (s)
      T_TLR:   return t ? T_TLR   : T_RTI;
      T_RTI:   return t ? T_SELDR : T_RTI;
      T_SELDR: return t ? T_SELIR : T_CAPDR;
      T_CAPDR: return t ? T_EX1DR : T_SHDR;
      T_SHDR:  return t ? T_EX1DR : T_SHDR;
      T_EX1DR: return t ? T_UPDR  : T_PADR;
      T_PADR:  return t ? T_EX2DR : T_PADR;
      T_EX2DR: return t ? T_UPDR  : T_SHDR;
      T_UPDR:  return t ? T_SELDR : T_RTI;
      T_SELIR: return t ? T_TLR   : T_CAPIR;
      T_CAPIR: return t ? T_EX1IR : T_SHIR;
      T_SHIR:  return t ? T_EX1IR : T_SHIR;
      T_EX1IR: return t ? T_UPIR  : T_PAIR;
      T_PAIR:  return t ? T_EX2IR : T_PAIR;
      T_EX2IR: return t ? T_UPIR  : T_SHIR;
      T_UPIR:  return t ? T_SELDR : T_RTI;
      default: return T_TLR;
    endcase
  endfunction

  // Behavioural TAP: IDCODE or 1-bit bypass DR, 4-bit IR capturing 0101
  tap_t        m_st   = T_PADR;
  logic [3:0]  m_ir   = 4'h0;
  logic [3:0]  m_irsh = 4'h0;
  logic [31:0] m_dr   = '0;
  logic        m_byp  = 1'b0;

  always @(posedge jtag_tck) begin
    n_rise++;
    tms_log.push_back(jtag_tms);
    case (m_st)
      T_TLR:   m_ir = IR_IDCODE;
      T_CAPDR: begin m_dr = IDCODE_VAL; m_byp = 1'b0; end
      T_SHDR: begin
        n_shift++;
        if (m_ir == IR_IDCODE) m_dr = {jtag_tdi, m_dr[31:1]};
        else                   m_byp = jtag_tdi;
      end
      T_CAPIR: m_irsh = 4'b0101;
      T_SHIR:  begin n_shift++; m_irsh = {jtag_tdi, m_irsh[3:1]}; end
      T_UPIR:  m_ir = m_irsh;
      default: ;
    endcase
    m_st = tap_next(m_st, jtag_tms);
  end

  always @(negedge jtag_tck) begin
    if (m_st == T_SHDR)      jtag_tdo = (m_ir == IR_IDCODE) ? m_dr[0] : m_byp;
    else if (m_st == T_SHIR) jtag_tdo = m_irsh[0];
    else                     jtag_tdo = 1'b0;
  end

  always @(posedge internal_clk) cyc++;

  always @(negedge internal_clk) begin
    if (reg_trstn && bus.rsp_valid === 1'b1) begin
      n_rsp++;
      if (sb.size() == 0) begin
        check_val("rsp_unexpected", bus.rsp_valid, 1'b0);
      end else begin
        sb_exp = sb.pop_front();
        check_val("rsp_data", bus.rsp_data, sb_exp);
      end
    end
  end

  task automatic send(input jtag_op_t op, input int len, input logic [MAX_LEN-1:0] data,
                      input bit exp_rsp, input logic [MAX_LEN-1:0] exp_data);
    int guard = 0;
    @(negedge internal_clk);
    while (bus.cmd_ready !== 1'b1 && guard < 2000) begin
      @(negedge internal_clk);
      guard++;
    end
    if (guard >= 2000) check_val("ready_timeout", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = LEN_W'(len);
    bus.cmd_data  = data;
    n_rise = 0;
    n_shift = 0;
    tms_log.delete();
    if (exp_rsp) sb.push_back(exp_data);
    t_acc = cyc + 1;
    @(posedge internal_clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '1;
  endtask

  task automatic wait_rsp(input string tag, output int lat);
    int guard = 0;
    logic [MAX_LEN-1:0] held;
    do begin
      @(negedge internal_clk);
      guard++;
    end while (bus.rsp_valid !== 1'b1 && guard < 2000);
    check_val({tag, "_rsp_seen"}, bus.rsp_valid, 1'b1);
    check_val({tag, "_ready_in_rsp"}, bus.cmd_ready, 1'b1);
    lat  = cyc - t_acc;
    held = bus.rsp_data;
    @(negedge internal_clk);
    check_val({tag, "_rsp_pulse"}, bus.rsp_valid, 1'b0);
    check_val({tag, "_rsp_hold"}, bus.rsp_data, held);
  endtask

  task automatic release_and_tlr(input string tag);
    int c0, r0, guard;
    @(negedge internal_clk);
    n_rise = 0;
    tms_log.delete();
    r0 = n_rsp;
    c0 = cyc;
    guard = 0;
    reg_trstn = 1'b1;
    do begin
      @(negedge internal_clk);
      guard++;
    end while (bus.cmd_ready !== 1'b1 && guard < 500);
    check_val({tag, "_tlr_clocks"}, cyc - c0, 6 * PER);
    check_val({tag, "_tlr_pulses"}, n_rise, 6);
    check_val({tag, "_tlr_tms"}, tms_bits(), 64'b111110);
    check_val({tag, "_tlr_no_rsp"}, n_rsp, r0);
    check_val({tag, "_tap_idle"}, m_st, T_RTI);
  endtask

  int lat;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_DR;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    repeat (3) @(negedge internal_clk);
    check_val("rst_tck", jtag_tck, 1'b0);
    check_val("rst_tms", jtag_tms, 1'b1);
    check_val("rst_tdi", jtag_tdi, 1'b0);
    check_val("rst_ready", bus.cmd_ready, 1'b0);
    check_val("rst_busy", bus.busy, 1'b1);
    check_val("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_val("rst_rsp_data", bus.rsp_data, '0);

    release_and_tlr("init");
    check_val("idle_tms", jtag_tms, 1'b0);
    check_val("idle_tck", jtag_tck, 1'b0);

    send(OP_IR, 4, 32'hF, 1'b1, 32'h5);
    wait_rsp("ir_bypass", lat);
    check_val("ir_periods", n_rise, 10);
    check_val("ir_tms", tms_bits(), 64'b1100000110);
    check_val("ir_model", m_ir, 4'hF);

    send(OP_DR, 8, 32'hA5, 1'b1, 32'h4A);
    wait_rsp("dr_bypass", lat);
    check_val("byp_latency", lat, 13 * PER);
    check_val("byp_periods", n_rise, 13);

    send(OP_IR, 4, 32'h1, 1'b1, 32'h5);
    wait_rsp("ir_idcode", lat);
    check_val("ir_idcode_model", m_ir, IR_IDCODE);

    send(OP_DR, 32, 32'h0, 1'b1, IDCODE_VAL);
    wait_rsp("dr_idcode", lat);
    check_val("idc_periods", n_rise, 37);
    check_val("idc_tail_tms", tms_bits() & 64'h7, 64'b110);
    check_val("idc_tap_idle", m_st, T_RTI);

    send(OP_RUNTEST, 3, 32'hFFFF_FFFF, 1'b1, 32'h0);
    wait_rsp("runtest", lat);
    check_val("rt_periods", n_rise, 3);
    check_val("rt_tms", tms_bits(), 64'b000);
    check_val("rt_latency", lat, 3 * PER);

    send(OP_DR, 0, 32'hFFFF_FFFF, 1'b1, 32'h0);
    wait_rsp("dr_zero", lat);
    check_val("zero_latency", lat, 2);
    check_val("zero_edges", n_rise, 0);

    send(OP_DR, 40, 32'h0, 1'b1, IDCODE_VAL);
    wait_rsp("dr_clamp", lat);
    check_val("clamp_shifts", n_shift, MAX_LEN);
    check_val("clamp_latency", lat, (MAX_LEN + 5) * PER);

    send(OP_TLR, 7, 32'hFFFF_FFFF, 1'b1, 32'h0);
    wait_rsp("tlr_cmd", lat);
    check_val("tlrc_periods", n_rise, 6);
    check_val("tlrc_tms", tms_bits(), 64'b111110);
    check_val("tlrc_tap_idle", m_st, T_RTI);

    send(OP_DR, 32, 32'hDEAD_BEEF, 1'b0, 32'h0);
    begin
      int guard = 0;
      while (n_shift < 5 && guard < 2000) begin
        @(negedge internal_clk);
        guard++;
      end
      check_val("midrst_in_shift", m_st, T_SHDR);
    end
    reg_trstn = 1'b0;
    #1;
    check_val("midrst_tms", jtag_tms, 1'b1);
    check_val("midrst_tck", jtag_tck, 1'b0);
    check_val("midrst_tdi", jtag_tdi, 1'b0);
    check_val("midrst_ready", bus.cmd_ready, 1'b0);
    check_val("midrst_busy", bus.busy, 1'b1);
    check_val("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    repeat (3) @(negedge internal_clk);
    release_and_tlr("midrst");

    repeat (4) @(negedge internal_clk);
    check_val("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", n_tests);
    $fatal(1);
  end
endmodule
`default_nettype wire
